// File: rtl/rgb_mixer_pkg.sv
// Shared definitions for the quadrature encoder: transition encodings, default
// parameter constants and the Gray-code transition classifier.
package rgb_mixer_pkg;

  localparam int DEF_WIDTH           = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_RESET_VALUE     = 0;

  typedef enum logic [1:0] {
    TR_NONE    = 2'd0,
    TR_UP      = 2'd1,
    TR_DOWN    = 2'd2,
    TR_ILLEGAL = 2'd3
  } trans_t;

  // Up follows 00->01->11->10->00. Every other single-bit change is the reverse walk.
  function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
    trans_t t;
    t = TR_NONE;
    if ((prev ^ cur) == 2'b11) begin
      t = TR_ILLEGAL;
    end else if (prev != cur) begin
      case ({prev, cur})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: t = TR_UP;
        default:                            t = TR_DOWN;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/quad_encoder_if.sv
// Encoder-side signal bundle: raw phases and clear in, position and event flags out.
interface quad_encoder_if
  import rgb_mixer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             enc_a;
  logic             enc_b;
  logic             clear;
  logic [WIDTH-1:0] value;
  logic             step;
  logic             dir;
  logic             err;

  modport master (
    output enc_a, enc_b, clear,
    input  value, step, dir, err
  );

  modport slave (
    input  enc_a, enc_b, clear,
    output value, step, dir, err
  );
endinterface

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a stability counter; the filtered output only
// follows the synchronized input after DEBOUNCE_CYCLES consecutive differing cycles.
module debounce
  import rgb_mixer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             filt_p2;
  logic [CNT_W-1:0] cnt;

  // Synchronizer stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage: any agreement with the filtered level restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_p2 <= 1'b0;
      cnt     <= '0;
    end else if (sync_p1 == filt_p2) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      filt_p2 <= sync_p1;
      cnt     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign filt = filt_p2;

endmodule

// File: rtl/quad_encoder.sv
// Quadrature encoder front end: debounced A/B phases decoded into a saturating
// position counter with step, direction and illegal-transition flags.
module quad_encoder
  import rgb_mixer_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RESET_VALUE     = DEF_RESET_VALUE
) (
  input logic           clk,
  input logic           reset,
  quad_encoder_if.slave bus
);

  localparam logic [WIDTH-1:0] VAL_INIT = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] VAL_MAX  = '1;
  localparam logic [WIDTH-1:0] VAL_MIN  = '0;

  logic             filt_a;
  logic             filt_b;
  logic [1:0]       ab_p0;
  logic [1:0]       ab_p1;
  trans_t           trans;
  logic [WIDTH-1:0] value_q;
  logic             step_q;
  logic             dir_q;
  logic             err_q;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == VAL_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == VAL_MIN) ? v : v - 1'b1;
  endfunction

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.enc_a),
    .filt  (filt_a)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.enc_b),
    .filt  (filt_b)
  );

  assign ab_p0 = {filt_a, filt_b};
  assign trans = classify(ab_p1, ab_p0);

  // Decode / accumulate stage: history always advances, even on illegal or cleared steps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ab_p1   <= 2'b00;
      value_q <= VAL_INIT;
      step_q  <= 1'b0;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      ab_p1  <= ab_p0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
      case (trans)
        TR_ILLEGAL: err_q <= 1'b1;
        TR_UP: begin
          if (!bus.clear) begin
            dir_q <= 1'b1;
            if (value_q != VAL_MAX) begin
              value_q <= sat_inc(value_q);
              step_q  <= 1'b1;
            end
          end
        end
        TR_DOWN: begin
          if (!bus.clear) begin
            dir_q <= 1'b0;
            if (value_q != VAL_MIN) begin
              value_q <= sat_dec(value_q);
              step_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (bus.clear) value_q <= VAL_INIT;
    end
  end

  assign bus.value = value_q;
  assign bus.step  = step_q;
  assign bus.dir   = dir_q;
  assign bus.err   = err_q;

endmodule

// File: doc/quad_encoder.md
QUAD_ENCODER -- requirements
Module: quad_encoder

Interface
REQ-001 Parameter WIDTH, default 8: width of the accumulated value.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept an input change; legal range is 1 to 65535.
REQ-003 Parameter RESET_VALUE, default 0: value loaded by reset and by clear.
REQ-004 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enc_a  input  1  raw quadrature phase A, asynchronous to clk, may bounce.
REQ-007 enc_b  input  1  raw quadrature phase B, asynchronous to clk, may bounce.
REQ-008 clear  input  1  synchronous; when high, value returns to RESET_VALUE.
REQ-009 value  output  WIDTH  accumulated position, registered; feeds the downstream PWM duty input.
REQ-010 step  output  1  one-cycle pulse when value changes because of encoder motion.
REQ-011 dir  output  1  direction of the last accepted step: 1 = up, 0 = down; registered.
REQ-012 err  output  1  one-cycle pulse when an illegal quadrature transition is detected.

Function
REQ-013 Each raw input SHALL pass through its own 2-flop synchronizer before any other logic uses it.
REQ-014 Each synchronized input SHALL have its own debounce counter, sized to hold DEBOUNCE_CYCLES.
- The counter resets to 0 on any cycle where the synchronized input equals the filtered input.
- The counter increments on any cycle where the two differ.
- When the count reaches DEBOUNCE_CYCLES-1 while they still differ, the filtered input takes the synchronized value on that edge and the counter returns to 0.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES clk cycles (after synchronization) SHALL NOT change the filtered input.
REQ-016 Decode SHALL compare the previous filtered pair {A,B} with the current filtered pair every cycle.
- Gray sequence 00→01→11→10→00 is an up step.
- The reverse sequence is a down step.
- An unchanged pair is no action.
- A change in both bits is illegal: err pulses, value is unchanged, and the current pair becomes the new previous pair.
REQ-017 On an up step, value SHALL increment by 1 and saturate at 2^WIDTH-1.
REQ-018 On a down step, value SHALL decrement by 1 and saturate at 0.
REQ-019 A step that is blocked by saturation SHALL NOT pulse step, but SHALL update dir.
REQ-020 Latency: value, step and dir SHALL update exactly 1 cycle after the filtered pair changes.
- Total latency from a clean raw edge to value is 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-021 clear SHALL take priority over a simultaneous step: value = RESET_VALUE, step = 0, dir unchanged, and the decoder history still updates.
REQ-022 step and err SHALL never be high in the same cycle.

Reset
REQ-023 While reset is high, the block SHALL hold:
- synchronizers, filtered inputs, previous pair and debounce counters at 0;
- value = RESET_VALUE;
- dir = 1, step = 0, err = 0.
REQ-024 Assertion of reset mid-debounce or mid-step SHALL discard the pending change immediately, with no output pulse after deassertion.
REQ-025 After deassertion, an input held at 11 SHALL be filtered in, and the resulting 00→11 transition SHALL be reported as err, not as a step.

Structure
REQ-026 The transition encodings (NONE, UP, DOWN, ILLEGAL) and the default parameter constants SHALL live in the shared package rgb_mixer_pkg.
REQ-027 The synchronizer plus debounce logic SHALL be one sub-module, debounce, instantiated once per phase.
- Decode and accumulation stay in quad_encoder.

Verification
REQ-028 The bench SHALL cover at least the following directed scenarios (DEBOUNCE_CYCLES=4, WIDTH=8 unless stated):
- 10 clean up sequences (4 edges each) from reset → value = 40, 40 step pulses, dir = 1, err never high.
- value = 254, then 3 up edges → value = 255, exactly 1 step pulse, dir = 1.
- value = 0, 1 down edge → value stays 0, no step pulse, dir = 0.
- A held high for 3 cycles amid stable inputs → no filtered change, value unchanged; held for 4 cycles → 1 step, value +1 at cycle 2+4+1 after the raw edge.
- A and B toggled in the same cycle from 00 → one err pulse, value unchanged, no step.
- clear asserted in the cycle the step would land → value = RESET_VALUE, no step; reset pulsed mid-debounce → all outputs at reset values, no pulse afterwards.
